serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 121 ++++++++++++
 tb/tb_serial_subtractor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = A - B (mod 2^WIDTH), one bit per clock, LSB first.
// Latency: START accepted at edge 0, bits processed at edges 1..WIDTH, DONE high for the cycle after edge WIDTH.
// Backpressure: none; START is only honoured in IDLE, and pulses seen in RUN or DONE are dropped, not queued.
//
// Ports:
//   CLK     - single clock, all state changes on the rising edge
//   RST_N   - asynchronous active-low reset
//   START   - request, sampled only while idle
//   A, B    - minuend / subtrahend, captured on the accepted START edge
//   BUSY    - high while bits are being processed
//   DONE    - one-cycle pulse when DIFF/BORROW carry a fresh result
//   DIFF    - A - B modulo 2^WIDTH, holds the last result
//   BORROW  - final borrow-out (A < B unsigned), holds the last result
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DIFF,
  output logic             BORROW
);

  // Counter must index WIDTH bits; keep at least one bit so WIDTH=1 still elaborates.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  // Full-subtractor cell on the current LSBs.
  assign a_bit   = sha[0];
  assign b_bit   = shb[0];
  assign d_bit   = a_bit ^ b_bit ^ br;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);

  assign last_bit = (cnt == LAST_CNT);

  // New difference bit enters at the MSB so that after WIDTH shifts bit 0 of
  // the result sits at bit 0. Written as shift/OR rather than a concatenation
  // so the WIDTH=1 case needs no zero-width slice.
  assign res_next = (res >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      sha    <= '0;
      shb    <= '0;
      res    <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      DIFF   <= '0;
      BORROW <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            sha   <= A;
            shb   <= B;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            BUSY  <= 1'b1;
            state <= S_RUN;
          end
        end

        S_RUN: begin
          sha <= sha >> 1;
          shb <= shb >> 1;
          res <= res_next;
          br  <= br_next;
          cnt <= cnt + CW'(1);
          if (last_bit) begin
            // Outputs only move here, so they stay stable during RUN.
            DIFF   <= res_next;
            BORROW <= br_next;
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          // START is deliberately not looked at here: no back-to-back accept.
          DONE  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;

  int checks = 0;
  int passed = 0;

  serial_subtractor #(.WIDTH(8)) u_sub8 (
    .CLK(clk), .RST_N(rst_n), .START(start8), .A(a8), .B(b8),
    .BUSY(busy8), .DONE(done8), .DIFF(diff8), .BORROW(borrow8)
  );

  serial_subtractor #(.WIDTH(1)) u_sub1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .A(a1), .B(b1),
    .BUSY(busy1), .DONE(done1), .DIFF(diff1), .BORROW(borrow1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one operation on the selected instance and observes it; it does
  // not judge anything. Samples are taken on negedges; sample i follows edge i
  // where edge 0 is the accepting edge. Operands are scrambled right after
  // the accepting edge to show they are not re-read.
  task automatic run_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] d, output logic br,
                        output int busy_n, output int done_n, output int lat,
                        output int hold_bad);
    logic [7:0] prev_d;
    logic       prev_b;
    logic [7:0] cur_d;
    logic       cur_b;
    int         w;
    w = w1 ? 1 : 8;
    @(negedge clk);
    if (w1) begin start1 = 1'b1; a1 = a[0]; b1 = b[0]; end
    else    begin start8 = 1'b1; a8 = a;    b8 = b;    end
    prev_d = w1 ? {7'b0, diff1} : diff8;
    prev_b = w1 ? borrow1 : borrow8;
    @(negedge clk);
    start1 = 1'b0; start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    a1 = 1'($urandom); b1 = 1'($urandom);
    busy_n = 0; done_n = 0; lat = -1; hold_bad = 0; d = 8'h00; br = 1'b0;
    for (int i = 0; i < w + 4; i++) begin
      cur_d = w1 ? {7'b0, diff1} : diff8;
      cur_b = w1 ? borrow1 : borrow8;
      if (w1 ? busy1 : busy8) begin
        busy_n++;
        if (cur_d !== prev_d || cur_b !== prev_b) hold_bad++;
      end
      if (w1 ? done1 : done8) begin
        done_n++;
        if (lat < 0) begin lat = i; d = cur_d; br = cur_b; end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy8, done8, diff8, borrow8} !== 11'h000) $display("FAIL reset8: got %h want 000", {busy8, done8, diff8, borrow8}); else passed++;
    checks++; if ({busy1, done1, diff1, borrow1} !== 4'h0) $display("FAIL reset1: got %h want 0", {busy1, done1, diff1, borrow1}); else passed++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy8, done8, diff8, borrow8} !== 11'h000) $display("FAIL idle_after_reset: got %h want 000", {busy8, done8, diff8, borrow8}); else passed++;
  endtask

  task automatic test_directed();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic [7:0] d;
    logic       br;
    int bn, dn, lat, hb;
    va = '{8'd5, 8'd3, 8'h80, 8'hFF, 8'h00};
    vb = '{8'd3, 8'd5, 8'h01, 8'hFF, 8'h00};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, va[i], vb[i], d, br, bn, dn, lat, hb);
      checks++; if (d !== 8'(va[i] - vb[i])) $display("FAIL dir_diff[%0d]: got %h want %h", i, d, 8'(va[i] - vb[i])); else passed++;
      checks++; if (br !== (va[i] < vb[i])) $display("FAIL dir_borrow[%0d]: got %b want %b", i, br, (va[i] < vb[i])); else passed++;
      checks++; if (lat !== 8) $display("FAIL dir_latency[%0d]: got %0d want 8", i, lat); else passed++;
      checks++; if (dn !== 1) $display("FAIL dir_done_pulses[%0d]: got %0d want 1", i, dn); else passed++;
      checks++; if (bn !== 8) $display("FAIL dir_busy_cycles[%0d]: got %0d want 8", i, bn); else passed++;
      checks++; if (hb !== 0) $display("FAIL dir_hold_during_run[%0d]: got %0d changes want 0", i, hb); else passed++;
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, d;
    logic       br;
    int bn, dn, lat, hb;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i == 0) b = a + 8'd1;
      run_op(1'b0, a, b, d, br, bn, dn, lat, hb);
      checks++; if ({d, br} !== {8'(a - b), (a < b)}) $display("FAIL rand[%0d] %h-%h: got %h/%b want %h/%b", i, a, b, d, br, 8'(a - b), (a < b)); else passed++;
      checks++; if (lat !== 8 || dn !== 1 || hb !== 0) $display("FAIL rand_timing[%0d]: got lat=%0d done=%0d holdbad=%0d want 8/1/0", i, lat, dn, hb); else passed++;
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] d;
    logic       br;
    int bn, dn, lat, hb, extra;
    bit seen;
    @(negedge clk); start8 = 1'b1; a8 = 8'd9; b8 = 8'd4;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // RUN cycle 3: a second request that must be dropped
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd2;
    @(negedge clk); start8 = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 12 && !seen; t++) begin
      if (done8) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (seen !== 1'b1) $display("FAIL ignore_done_seen: got %b want 1", seen); else passed++;
    checks++; if ({diff8, borrow8} !== {8'd5, 1'b0}) $display("FAIL ignore_result: got %h/%b want 05/0", diff8, borrow8); else passed++;
    extra = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    checks++; if (extra !== 0) $display("FAIL ignore_not_queued: got %0d active cycles want 0", extra); else passed++;
    run_op(1'b0, 8'd1, 8'd2, d, br, bn, dn, lat, hb);
    checks++; if ({d, br} !== {8'hFF, 1'b1}) $display("FAIL ignore_next_op: got %h/%b want ff/1", d, br); else passed++;
  endtask

  task automatic test_async_reset();
    logic [7:0] d;
    logic       br;
    int bn, dn, lat, hb, act;
    @(negedge clk); start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
    @(negedge clk); start8 = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    // RUN cycle 4, mid-cycle, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy8, done8, diff8, borrow8} !== 11'h000) $display("FAIL async_reset_outputs: got %h want 000", {busy8, done8, diff8, borrow8}); else passed++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (done8 || busy8 || diff8 !== 8'h00) act++;
    end
    checks++; if (act !== 0) $display("FAIL async_reset_no_partial: got %0d active cycles want 0", act); else passed++;
    run_op(1'b0, 8'd7, 8'd2, d, br, bn, dn, lat, hb);
    checks++; if ({d, br} !== {8'd5, 1'b0}) $display("FAIL async_reset_recover: got %h/%b want 05/0", d, br); else passed++;
  endtask

  task automatic test_width1();
    logic [7:0] d;
    logic       br;
    int bn, dn, lat, hb;
    logic [1:0] ea, eb;
    for (int i = 0; i < 4; i++) begin
      ea = (i == 0) ? 2'd0 : 2'(i >> 1);
      eb = (i == 0) ? 2'd1 : 2'(i & 1);
      run_op(1'b1, {6'b0, ea}, {6'b0, eb}, d, br, bn, dn, lat, hb);
      checks++; if ({d[0], br} !== {1'((ea - eb) & 2'd1), (ea < eb)}) $display("FAIL w1[%0d] %0d-%0d: got %b/%b want %b/%b", i, ea, eb, d[0], br, 1'((ea - eb) & 2'd1), (ea < eb)); else passed++;
      checks++; if (lat !== 1 || bn !== 1 || dn !== 1) $display("FAIL w1_timing[%0d]: got lat=%0d busy=%0d done=%0d want 1/1/1", i, lat, bn, dn); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int n, first, second;
    @(negedge clk); start8 = 1'b1; a8 = 8'h20; b8 = 8'h0F;
    n = 0; first = -1; second = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done8) begin
        n++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    start8 = 1'b0;
    checks++; if (n !== 3) $display("FAIL b2b_count: got %0d want 3", n); else passed++;
    checks++; if (first !== 8) $display("FAIL b2b_first: got %0d want 8", first); else passed++;
    checks++; if (second - first !== 10) $display("FAIL b2b_spacing: got %0d want 10", second - first); else passed++;
    checks++; if ({diff8, borrow8} !== {8'h11, 1'b0}) $display("FAIL b2b_result: got %h/%b want 11/0", diff8, borrow8); else passed++;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_async_reset();
    test_width1();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
